// File: rtl/adder_response_checker_if.sv
// Bus bundle between the adder stimulus/response side and adder_response_checker.
// The cin field exists only when ADDER_CHK_CARRY_IN_EN is defined.
interface adder_response_checker_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             vec_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             C;
`ifdef ADDER_CHK_CARRY_IN_EN
    logic             cin;
`endif
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic             first_fail_valid;
    logic [CNT_W-1:0] first_fail_idx;

    modport master (
        output start, num_vectors, vec_valid, A, B, S, C,
`ifdef ADDER_CHK_CARRY_IN_EN
        output cin,
`endif
        input  busy, done, pass, vec_count, err_count, first_fail_valid, first_fail_idx
    );

    modport slave (
        input  start, num_vectors, vec_valid, A, B, S, C,
`ifdef ADDER_CHK_CARRY_IN_EN
        input  cin,
`endif
        output busy, done, pass, vec_count, err_count, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/adder_response_checker.sv
// Response monitor for half/full/ripple adders: compares S/C against A+B(+cin) and counts errors.
// Optional feature macro ADDER_CHK_CARRY_IN_EN adds cin to the golden sum (full-adder checking).
module adder_response_checker #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    adder_response_checker_if.slave bus
);
    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] vec_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic             ff_valid_q;
    logic [CNT_W-1:0] ff_idx_q;

    logic [SUM_W-1:0] sum_exp_c;
    logic             mismatch_c;
    logic [CNT_W-1:0] count_inc_c;

    // Golden sum at WIDTH+1 bits; carry is the MSB.
    always_comb begin
`ifdef ADDER_CHK_CARRY_IN_EN
        sum_exp_c = SUM_W'(bus.A) + SUM_W'(bus.B) + SUM_W'(bus.cin);
`else
        sum_exp_c = SUM_W'(bus.A) + SUM_W'(bus.B);
`endif
        mismatch_c  = ({bus.C, bus.S} != sum_exp_c);
        count_inc_c = vec_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            target      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vec_count_q <= '0;
            err_count_q <= '0;
            ff_valid_q  <= 1'b0;
            ff_idx_q    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // start wins over any coincident vector; a zero-length run completes at once
                    if (bus.start) begin
                        target      <= bus.num_vectors;
                        vec_count_q <= '0;
                        err_count_q <= '0;
                        ff_valid_q  <= 1'b0;
                        ff_idx_q    <= '0;
                        if (bus.num_vectors == '0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            pass_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.vec_valid) begin
                        vec_count_q <= count_inc_c;
                        if (mismatch_c) begin
                            if (err_count_q != '1) begin
                                err_count_q <= err_count_q + CNT_W'(1);
                            end
                            if (!ff_valid_q) begin
                                ff_valid_q <= 1'b1;
                                ff_idx_q   <= vec_count_q;
                            end
                        end
                        if (count_inc_c == target) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= !mismatch_c && (err_count_q == '0);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    pass_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.vec_count        = vec_count_q;
    assign bus.err_count        = err_count_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_idx   = ff_idx_q;
endmodule

// File: tb/tb_adder_response_checker.sv
// Randomized + directed bench for adder_response_checker; two instances (1-bit/8-bit counters, 4-bit/2-bit counters).
// Honors ADDER_CHK_CARRY_IN_EN when defined.
module tb_adder_response_checker;
    localparam int unsigned W0 = 1;
    localparam int unsigned C0 = 8;
    localparam int unsigned W1 = 4;
    localparam int unsigned C1 = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_response_checker_if #(.WIDTH(W0), .CNT_W(C0)) bus0 ();
    adder_response_checker_if #(.WIDTH(W1), .CNT_W(C1)) bus1 ();

    adder_response_checker #(.WIDTH(W0), .CNT_W(C0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    adder_response_checker #(.WIDTH(W1), .CNT_W(C1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run phase, target, vectors seen, total (unsaturated) mismatches, first bad index.
    int m_state [2];
    int m_target[2];
    int m_cnt   [2];
    int m_tot   [2];
    int m_first [2];
    int m_width [2] = '{int'(W0), int'(W1)};
    int m_max   [2] = '{(1 << C0) - 1, (1 << C1) - 1};

    task automatic check(input string tag, input logic [31:0] got, input int ev);
        n_checks++;
        if (got !== 32'(ev)) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, ev);
        end
    endtask

    task automatic model_edge(input int sel, input bit rst, input bit st, input int nv,
                              input bit vv, input bit mism);
        if (rst) begin
            m_state[sel] = M_IDLE;
            m_cnt[sel]   = 0;
            m_tot[sel]   = 0;
            m_first[sel] = -1;
        end else if (m_state[sel] != M_RUN) begin
            if (st) begin
                m_target[sel] = nv;
                m_cnt[sel]    = 0;
                m_tot[sel]    = 0;
                m_first[sel]  = -1;
                m_state[sel]  = (nv == 0) ? M_DONE : M_RUN;
            end
        end else if (vv) begin
            if (mism) begin
                if (m_first[sel] < 0) m_first[sel] = m_cnt[sel];
                m_tot[sel]++;
            end
            m_cnt[sel]++;
            if (m_cnt[sel] == m_target[sel]) m_state[sel] = M_DONE;
        end
    endtask

    task automatic check_dut(input int sel, input string tag);
        logic [31:0] act[7];
        int          ev [7];
        string       nm [7];
        nm = '{"busy", "done", "pass", "vec_count", "err_count", "ff_valid", "ff_idx"};
        ev[0] = (m_state[sel] == M_RUN)  ? 1 : 0;
        ev[1] = (m_state[sel] == M_DONE) ? 1 : 0;
        ev[2] = (m_state[sel] == M_DONE && m_tot[sel] == 0) ? 1 : 0;
        ev[3] = m_cnt[sel];
        ev[4] = (m_tot[sel] > m_max[sel]) ? m_max[sel] : m_tot[sel];
        ev[5] = (m_first[sel] >= 0) ? 1 : 0;
        ev[6] = (m_first[sel] >= 0) ? m_first[sel] : 0;
        if (sel == 0) begin
            act[0] = 32'(bus0.busy);      act[1] = 32'(bus0.done);
            act[2] = 32'(bus0.pass);      act[3] = 32'(bus0.vec_count);
            act[4] = 32'(bus0.err_count); act[5] = 32'(bus0.first_fail_valid);
            act[6] = 32'(bus0.first_fail_idx);
        end else begin
            act[0] = 32'(bus1.busy);      act[1] = 32'(bus1.done);
            act[2] = 32'(bus1.pass);      act[3] = 32'(bus1.vec_count);
            act[4] = 32'(bus1.err_count); act[5] = 32'(bus1.first_fail_valid);
            act[6] = 32'(bus1.first_fail_idx);
        end
        for (int i = 0; i < 7; i++) check($sformatf("%s/d%0d/%s", tag, sel, nm[i]), act[i], ev[i]);
    endtask

    // One clock: drive the selected instance, advance the model at the edge, then compare both.
    task automatic cycle(input int sel, input bit rst, input bit st, input int nv, input bit vv,
                         input int a, input int b, input int s, input int c, input int ci,
                         input string tag);
        int  mask;
        int  eff_ci;
        bit  mism;
        mask = (1 << m_width[sel]) - 1;
`ifdef ADDER_CHK_CARRY_IN_EN
        eff_ci = ci & 1;
`else
        eff_ci = 0;
`endif
        mism = (((a & mask) + (b & mask) + eff_ci) != ((s & mask) + ((c & 1) << m_width[sel])));
        rst_n = !rst;
        bus0.start = 1'b0; bus0.vec_valid = 1'b0;
        bus1.start = 1'b0; bus1.vec_valid = 1'b0;
        if (sel == 0) begin
            bus0.start = st; bus0.vec_valid = vv; bus0.num_vectors = C0'(nv);
            bus0.A = W0'(a); bus0.B = W0'(b); bus0.S = W0'(s); bus0.C = 1'(c);
`ifdef ADDER_CHK_CARRY_IN_EN
            bus0.cin = 1'(ci);
`endif
        end else begin
            bus1.start = st; bus1.vec_valid = vv; bus1.num_vectors = C1'(nv);
            bus1.A = W1'(a); bus1.B = W1'(b); bus1.S = W1'(s); bus1.C = 1'(c);
`ifdef ADDER_CHK_CARRY_IN_EN
            bus1.cin = 1'(ci);
`endif
        end
        @(posedge clk);
        model_edge(sel, rst, st, nv, vv, mism);
        model_edge(1 - sel, rst, 1'b0, 0, 1'b0, 1'b0);
        #1;
        check_dut(0, tag);
        check_dut(1, tag);
    endtask

    // Random vector: correct sum, optionally corrupted in S or C.
    task automatic rnd_vec(input int sel, input bit st);
        int a, b, ci, sum, s, c, f, mask;
        mask = (1 << m_width[sel]) - 1;
        a    = int'($urandom) & mask;
        b    = int'($urandom) & mask;
        ci   = int'($urandom_range(0, 1));
`ifdef ADDER_CHK_CARRY_IN_EN
        sum = a + b + ci;
`else
        sum = a + b;
`endif
        s = sum & mask;
        c = (sum >> m_width[sel]) & 1;
        f = int'($urandom_range(0, 5));
        if (f == 0) s = s ^ (int'($urandom_range(1, 15)) & mask | 1);
        if (f == 1) c = c ^ 1;
        cycle(sel, 1'b0, st, int'($urandom_range(0, 3)), 1'b1, a, b, s, c, ci, "rnd_vec");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE; m_target[i] = 0; m_cnt[i] = 0; m_tot[i] = 0; m_first[i] = -1;
        end
        bus0.num_vectors = '0; bus0.A = '0; bus0.B = '0; bus0.S = '0; bus0.C = 1'b0;
        bus1.num_vectors = '0; bus1.A = '0; bus1.B = '0; bus1.S = '0; bus1.C = 1'b0;
`ifdef ADDER_CHK_CARRY_IN_EN
        bus0.cin = 1'b0; bus1.cin = 1'b0;
`endif

        // Reset state
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        cycle(0, 1, 1, 4, 1, 1, 1, 0, 1, 0, "rst_hold");
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_vec", 32'(bus0.vec_count), 0);

        // Exhaustive 1-bit, correct responses
        cycle(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, "t1_start");
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "t1_v0");
        cycle(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, "t1_v1");
        cycle(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, "t1_v2");
        check("t1_not_done_yet", 32'(bus0.done), 0);
        cycle(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, "t1_v3");
        check("t1_done", 32'(bus0.done), 1);
        check("t1_vec", 32'(bus0.vec_count), 4);
        check("t1_pass", 32'(bus0.pass), 1);
        cycle(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "t1_ignore_in_done");

        // Injected faults at vectors 2 (S) and 3 (C); restart straight from DONE
        cycle(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, "t2_start");
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "t2_v0");
        cycle(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, "t2_v1");
        cycle(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "t2_v2");
        cycle(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, "t2_v3");
        check("t2_err", 32'(bus0.err_count), 2);
        check("t2_ffv", 32'(bus0.first_fail_valid), 1);
        check("t2_ffidx", 32'(bus0.first_fail_idx), 2);
        check("t2_pass", 32'(bus0.pass), 0);

        // Zero-length run; coincident vector is not counted
        cycle(0, 0, 1, 0, 1, 1, 1, 0, 0, 0, "t3_zero");
        check("t3_done", 32'(bus0.done), 1);
        check("t3_pass", 32'(bus0.pass), 1);
        check("t3_vec", 32'(bus0.vec_count), 0);

        // Gaps of two idle cycles; num_vectors changes mid-run are ignored
        cycle(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, "t4_start");
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 9, 0, 1, 1, 0, 0, 0, "t4_gap");
            cycle(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, "t4_gap");
            cycle(0, 0, 0, 5, 1, 1, k & 1, (k & 1) ? 0 : 1, k & 1, 0, "t4_vec");
        end
        check("t4_vec", 32'(bus0.vec_count), 3);
        check("t4_done", 32'(bus0.done), 1);

        // 2-bit counters: all three vectors wrong, start in RUN ignored, then restart
        cycle(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, "t5_start");
        cycle(1, 0, 0, 0, 1, 3, 4, 0, 0, 0, "t5_v0");
        cycle(1, 0, 1, 0, 1, 9, 9, 2, 0, 0, "t5_v1_start_ignored");
        cycle(1, 0, 0, 0, 1, 15, 1, 0, 0, 0, "t5_v2");
        check("t5_err", 32'(bus1.err_count), 3);
        check("t5_done", 32'(bus1.done), 1);
        cycle(1, 0, 1, 2, 1, 1, 1, 0, 0, 0, "t5_restart");
        check("t5_rs_vec", 32'(bus1.vec_count), 0);
        check("t5_rs_err", 32'(bus1.err_count), 0);
        check("t5_rs_ffv", 32'(bus1.first_fail_valid), 0);
        check("t5_rs_busy", 32'(bus1.busy), 1);

        // Reset mid-run, then vectors without start are ignored
        cycle(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, "t6_start");
        cycle(0, 0, 0, 0, 1, 1, 1, 1, 1, 0, "t6_v0");
        cycle(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, "t6_v1");
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "t6_rst");
        check("t6_rst_ffv", 32'(bus0.first_fail_valid), 0);
        cycle(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, "t6_ign0");
        cycle(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, "t6_ign1");
        check("t6_vec", 32'(bus0.vec_count), 0);
        check("t6_busy", 32'(bus0.busy), 0);

`ifdef ADDER_CHK_CARRY_IN_EN
        // Full-adder carry-in check on the 4-bit instance
        cycle(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, "t7_start");
        cycle(1, 0, 0, 0, 1, 15, 0, 0, 1, 1, "t7_ok");
        check("t7_ok_err", 32'(bus1.err_count), 0);
        cycle(1, 0, 0, 0, 1, 15, 0, 0, 0, 1, "t7_bad");
        check("t7_bad_err", 32'(bus1.err_count), 1);
`endif

        // Randomized runs on both instances
        for (int r = 0; r < 40; r++) begin
            int sel;
            int nv;
            int guard;
            sel   = r % 2;
            nv    = (sel == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 12));
            guard = 0;
            cycle(sel, 0, 1, nv, $urandom_range(0, 1), 1, 1, 0, 0, 0, "rnd_start");
            while (m_state[sel] == M_RUN && guard < 100) begin
                guard++;
                if ($urandom_range(0, 3) == 0)
                    cycle(sel, 0, $urandom_range(0, 1), int'($urandom_range(0, 3)), 0,
                          int'($urandom), int'($urandom), int'($urandom), 0, 0, "rnd_gap");
                else
                    rnd_vec(sel, $urandom_range(0, 7) == 0);
            end
            check("rnd_done", 32'((sel == 0) ? bus0.done : bus1.done), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_response_checker.md
Name: adder_response_checker

Overview:
- Self-checking response monitor for the adder family (half adder, full adder, N-bit ripple adder).
- Sits on the DUT's output side, opposite the stimulus driver. Each strobe it samples the applied operands and the DUT's S/C outputs, compares them against a golden sum, and counts vectors and mismatches.
- Reports pass/fail and the index of the first failure once the programmed vector count has been checked.

Parameters:
- WIDTH, 1, operand and sum width in bits (1 = half adder, legal range 1..16).
- CNT_W, 8, width of the vector and error counters.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; arms a check run.
- num_vectors  in  CNT_W  vectors expected in this run; sampled on start.
- vec_valid  in  1  A/B/S/C are valid this cycle.
- A  in  WIDTH  operand applied to the DUT.
- B  in  WIDTH  operand applied to the DUT.
- S  in  WIDTH  DUT sum output.
- C  in  1  DUT carry output.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  done && err_count==0.
- vec_count  out  CNT_W  vectors checked in this run.
- err_count  out  CNT_W  mismatching vectors; saturates.
- first_fail_valid  out  1  at least one mismatch seen.
- first_fail_idx  out  CNT_W  0-based index of the first mismatching vector.

Behaviour:
- Reset: synchronous, active-low; one clock, rst_n sampled on rising clk.
  - While rst_n=0, state=IDLE and every output is 0.
  - Reset during RUN or DONE aborts the run. The next start begins clean.
- Golden model: {C_exp,S_exp} = A + B (+cin if feature enabled), computed at WIDTH+1 bits, zero-extended.
  - Mismatch = (S!=S_exp) || (C!=C_exp).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start: latch num_vectors, clear vec_count, err_count, first_fail_valid and first_fail_idx.
  - If the latched value is 0, go to DONE; otherwise go to RUN.
- RUN, on each edge with vec_valid=1:
  - vec_count increments.
  - On a mismatch, err_count increments. It saturates at 2^CNT_W-1 and never wraps.
  - On the first mismatch, first_fail_idx takes the pre-increment vec_count and first_fail_valid is set.
  - When the incremented vec_count equals the latched target, go to DONE on that same edge.
  - Latency: counters and flags reflect vector k on the cycle after its vec_valid edge; done rises the cycle after the last vector is accepted.
- Inputs ignored:
  - vec_valid=0 cycles are ignored (gaps allowed).
  - start during RUN is ignored.
  - vec_valid in IDLE or DONE is ignored; counters hold.
- DONE:
  - done=1; all results held.
  - pass=1 iff err_count==0.
  - start restarts exactly as from IDLE; same-cycle clear-and-latch, no idle cycle required.
- Simultaneous start and vec_valid:
  - In IDLE/DONE, start wins and that vector is not counted.
  - In RUN, the vector is counted and start is ignored.
- num_vectors changes after start have no effect on the current run.

Optional Feature:
- Macro: ADDER_CHK_CARRY_IN_EN.
- Defined: adds input port cin (1 bit, qualified by vec_valid); golden sum = A + B + cin, which checks full-adder DUTs.
- Undefined: no cin port; golden sum = A + B (half-adder semantics).
- All other behaviour is identical in both builds.

Test Plan:
- Exhaustive 1-bit, correct responses:
  - Stimulus: start with num_vectors=4; vectors (A,B)=(0,0),(0,1),(1,0),(1,1) with correct S/C = 0/0, 1/0, 1/0, 0/1.
  - Response: done one cycle after the 4th vector, vec_count=4, err_count=0, pass=1, first_fail_valid=0.
- Injected faults:
  - Stimulus: same run, but vector index 2 has S forced to 0 and vector 3 has C forced to 0.
  - Response: err_count=2, first_fail_valid=1, first_fail_idx=2, pass=0.
- Zero-length run and gaps:
  - Stimulus: num_vectors=0 with start.
  - Response: DONE next cycle, pass=1, vec_count=0.
  - Stimulus: a 3-vector run with 2 idle cycles between each vector.
  - Response: vec_count=3 and done only after the 3rd vector.
- Saturation and restart:
  - Stimulus: CNT_W=2, num_vectors=3, all 3 vectors mismatching, then start again.
  - Response: err_count=3 (no wrap); the restart clears all counters the next cycle.
- Reset mid-run:
  - Stimulus: rst_n=0 for one cycle after 2 of 4 vectors.
  - Response: IDLE, all outputs 0; subsequent vec_valid is ignored until start.
- ADDER_CHK_CARRY_IN_EN, WIDTH=4:
  - Stimulus: A=4'hF, B=4'h0, cin=1, DUT S=4'h0, C=1.
  - Response: no error.
  - Stimulus: DUT C=0 for the same inputs.
  - Response: err_count=1.
